// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and constants for the MAC job controller and the MAC wrapper.
package mac_seq_ctrl_pkg;

    localparam int MAC_LATENCY_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_valid_pipe.sv
// Shift register tracking which MAC pipeline slots hold a real operand.
// tail lines up with mac_out; any_inflight covers the slots still ahead of the tail.
module mac_valid_pipe
    import mac_seq_ctrl_pkg::*;
#(
    parameter int DEPTH = MAC_LATENCY_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic tail,
    output logic any_inflight
);

    logic [DEPTH-1:0] pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tail         = pipe[DEPTH-1];
    assign any_inflight = |(pipe & ~(DEPTH'(1) << (DEPTH - 1)));

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product job controller: streams (a, y) pairs into the pipelined MAC and
// accumulates the products that come back MAC_LATENCY edges later.
//
//   state | meaning
//   IDLE  | waiting for start; result of the last job still visible
//   FEED  | accepting pairs until the job length is exhausted
//   DRAIN | no new input; waiting for in-flight products to be accumulated
//   DONE  | result valid, held until res_ready
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int PROD_W      = 6,
    parameter int MAC_LATENCY = MAC_LATENCY_DEF,
    parameter int LEN_W       = 4,
    parameter int ACC_W       = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_y,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_y,
    input  logic [PROD_W-1:0] mac_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_ovf
);

    localparam int SUM_W = ACC_W + 1;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  remaining;
    logic [ACC_W-1:0]  acc;
    logic              ovf;
    logic              fire;
    logic              tail;
    logic              upstream;
    logic [SUM_W-1:0]  sum;

    assign fire = (state == FEED) && in_valid;
    assign sum  = {1'b0, acc} + SUM_W'(mac_out);

    mac_valid_pipe #(
        .DEPTH (MAC_LATENCY)
    ) u_valid_pipe (
        .clk          (clk),
        .rst          (rst),
        .din          (fire),
        .tail         (tail),
        .any_inflight (upstream)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                if (fire && (remaining == LEN_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Only zeros enter the pipe here, so an empty upstream means this tail is the last one.
                if (tail && !upstream) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if ((state == IDLE) && start) begin
            remaining <= len;
            acc       <= '0;
            ovf       <= 1'b0;
        end else begin
            if (fire) begin
                remaining <= remaining - LEN_W'(1);
            end
            if (tail) begin
                acc <= sum[ACC_W-1:0];
                if (sum[ACC_W]) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    assign busy      = (state != IDLE);
    assign in_ready  = (state == FEED);
    assign res_valid = (state == DONE);
    assign res_data  = acc;
    assign res_ovf   = ovf;
    assign mac_a     = (fire && !rst) ? in_a : '0;
    assign mac_y     = (fire && !rst) ? in_y : '0;

endmodule
